// File: rtl/bcd_counter_2digit_if.sv
// Board-side bundle of the two-digit BCD counter: control inputs, load value and digit/status outputs.
interface bcd_counter_2digit_if;
  logic       EN;
  logic       UP;
  logic       LOAD;
  logic       STEP;
  logic [7:0] LOAD_VAL;
  logic [3:0] DIGIT1;
  logic [3:0] DIGIT0;
  logic       WRAP;
  logic       LOAD_ERR;

  modport master (
    output EN, UP, LOAD, STEP, LOAD_VAL,
    input  DIGIT1, DIGIT0, WRAP, LOAD_ERR
  );

  modport slave (
    input  EN, UP, LOAD, STEP, LOAD_VAL,
    output DIGIT1, DIGIT0, WRAP, LOAD_ERR
  );
endinterface

// File: rtl/bcd_counter_2digit.sv
// Two-digit BCD up/down counter with prescaled run mode, paused single-step,
// and parallel load from DIP switches; all board inputs are synchronized.
module bcd_counter_2digit #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned TICK_HZ     = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                    CLOCK_50,
  input logic                    RST_N,
  bcd_counter_2digit_if.slave    bus
);

  localparam int unsigned PRESCALE = CLK_HZ / TICK_HZ;
  localparam int unsigned PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [SYNC_STAGES-1:0] en_sync, up_sync, load_sync, step_sync;
  logic                   load_d, step_d;
  logic [PW-1:0]          presc_q, presc_n;
  logic [3:0]             digit1_q, digit0_q, digit1_n, digit0_n;
  logic                   wrap_q, wrap_n;
  logic                   err_q, err_n;

  logic en_s, up_s, load_s, step_s;
  logic load_rise, step_fall, tick, count_ev, carry;

  assign en_s   = en_sync[SYNC_STAGES-1];
  assign up_s   = up_sync[SYNC_STAGES-1];
  assign load_s = load_sync[SYNC_STAGES-1];
  assign step_s = step_sync[SYNC_STAGES-1];

  assign load_rise = load_s & ~load_d;
  assign step_fall = ~step_s & step_d;
  assign tick      = en_s && (presc_q == PW'(PRESCALE - 1));
  assign count_ev  = tick || (step_fall && !en_s);

  // State register; STEP chain idles high because the button is active-low.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      en_sync   <= '0;
      up_sync   <= '0;
      load_sync <= '0;
      step_sync <= '1;
      load_d    <= 1'b0;
      step_d    <= 1'b1;
      presc_q   <= '0;
      digit1_q  <= 4'd0;
      digit0_q  <= 4'd0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      en_sync   <= {en_sync[SYNC_STAGES-2:0], bus.EN};
      up_sync   <= {up_sync[SYNC_STAGES-2:0], bus.UP};
      load_sync <= {load_sync[SYNC_STAGES-2:0], bus.LOAD};
      step_sync <= {step_sync[SYNC_STAGES-2:0], bus.STEP};
      load_d    <= load_s;
      step_d    <= step_s;
      presc_q   <= presc_n;
      digit1_q  <= digit1_n;
      digit0_q  <= digit0_n;
      wrap_q    <= wrap_n;
      err_q     <= err_n;
    end
  end

  // Next state: load beats count; out-of-range digits are forced to the wrap value.
  always_comb begin
    presc_n  = presc_q;
    digit1_n = digit1_q;
    digit0_n = digit0_q;
    wrap_n   = 1'b0;
    err_n    = err_q;
    carry    = 1'b0;

    if (!en_s || load_rise || tick) begin
      presc_n = '0;
    end else begin
      presc_n = presc_q + PW'(1);
    end

    if (load_rise) begin
      if ((bus.LOAD_VAL[7:4] <= 4'd9) && (bus.LOAD_VAL[3:0] <= 4'd9)) begin
        digit1_n = bus.LOAD_VAL[7:4];
        digit0_n = bus.LOAD_VAL[3:0];
        err_n    = 1'b0;
      end else begin
        err_n    = 1'b1;
      end
    end else if (count_ev) begin
      if (up_s) begin
        if (digit0_q == 4'd9) begin
          digit0_n = 4'd0;
          carry    = 1'b1;
        end else if (digit0_q > 4'd9) begin
          digit0_n = 4'd0;
        end else begin
          digit0_n = digit0_q + 4'd1;
        end
        if (digit1_q > 4'd9) begin
          digit1_n = 4'd0;
        end else if (carry) begin
          if (digit1_q == 4'd9) begin
            digit1_n = 4'd0;
            wrap_n   = 1'b1;
          end else begin
            digit1_n = digit1_q + 4'd1;
          end
        end
      end else begin
        if (digit0_q == 4'd0) begin
          digit0_n = 4'd9;
          carry    = 1'b1;
        end else if (digit0_q > 4'd9) begin
          digit0_n = 4'd9;
        end else begin
          digit0_n = digit0_q - 4'd1;
        end
        if (digit1_q > 4'd9) begin
          digit1_n = 4'd9;
        end else if (carry) begin
          if (digit1_q == 4'd0) begin
            digit1_n = 4'd9;
            wrap_n   = 1'b1;
          end else begin
            digit1_n = digit1_q - 4'd1;
          end
        end
      end
    end
  end

  assign bus.DIGIT1   = digit1_q;
  assign bus.DIGIT0   = digit0_q;
  assign bus.WRAP     = wrap_q;
  assign bus.LOAD_ERR = err_q;

endmodule

// File: tb/tb_bcd_counter_2digit.sv
// Directed bench for bcd_counter_2digit with a small prescaler (10 cycles per tick).
module tb_bcd_counter_2digit;

  logic CLOCK_50 = 1'b0;
  logic RST_N;

  bcd_counter_2digit_if bus();

  bcd_counter_2digit #(
    .CLK_HZ      (10),
    .TICK_HZ     (1),
    .SYNC_STAGES (2)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RST_N    (RST_N),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  // Expected {tens, units, wrap, load_err} and a tag per scoreboard entry.
  logic [9:0] exp_q[$];
  string      tag_q[$];

  task automatic wait_n(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic push(input string tag, input logic [7:0] val, input logic w, input logic e);
    exp_q.push_back({val, w, e});
    tag_q.push_back(tag);
  endtask

  task automatic chk();
    logic [9:0] exp_v;
    logic [9:0] obs_v;
    string      tag;
    exp_v = exp_q.pop_front();
    tag   = tag_q.pop_front();
    obs_v = {bus.DIGIT1, bus.DIGIT0, bus.WRAP, bus.LOAD_ERR};
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s: observed digits=%h%h wrap=%b err=%b, expected digits=%h%h wrap=%b err=%b",
             tag, obs_v[9:6], obs_v[5:2], obs_v[1], obs_v[0],
             exp_v[9:6], exp_v[5:2], exp_v[1], exp_v[0]);
    end
  endtask

  function automatic logic [7:0] bcd(input int k);
    return {4'(k / 10), 4'(k % 10)};
  endfunction

  // Load while paused: old value two edges in, new value on the third, then release LOAD.
  task automatic do_load(input string tag, input logic [7:0] v,
                         input logic [7:0] old_v, input logic old_e,
                         input logic [7:0] new_v, input logic new_e);
    bus.LOAD_VAL = v;
    bus.LOAD     = 1'b1;
    push({tag, "_before"}, old_v, 1'b0, old_e);
    wait_n(2); chk();
    push({tag, "_after"}, new_v, 1'b0, new_e);
    wait_n(1); chk();
    bus.LOAD = 1'b0;
    wait_n(3);
  endtask

  initial begin
    RST_N        = 1'b0;
    bus.EN       = 1'b1;
    bus.UP       = 1'b1;
    bus.LOAD     = 1'b0;
    bus.STEP     = 1'b1;
    bus.LOAD_VAL = 8'h00;

    // Reset and run
    push("reset", 8'h00, 1'b0, 1'b0);
    wait_n(3); chk();
    RST_N = 1'b1;
    push("run_pre_first", 8'h00, 1'b0, 1'b0);
    wait_n(11); chk();
    push("run_first", 8'h01, 1'b0, 1'b0);
    wait_n(1); chk();
    for (int k = 2; k <= 10; k++) begin
      push("run_hold", bcd(k - 1), 1'b0, 1'b0);
      wait_n(9); chk();
      push("run_step", bcd(k), 1'b0, 1'b0);
      wait_n(1); chk();
    end

    // Pause, load 98, run up through the wrap, then reverse
    bus.EN = 1'b0;
    push("pause_hold", 8'h10, 1'b0, 1'b0);
    wait_n(3); chk();
    do_load("load98", 8'h98, 8'h10, 1'b0, 8'h98, 1'b0);
    bus.EN = 1'b1;
    push("up_pre", 8'h98, 1'b0, 1'b0);
    wait_n(11); chk();
    push("up_99", 8'h99, 1'b0, 1'b0);
    wait_n(1); chk();
    push("up_99_hold", 8'h99, 1'b0, 1'b0);
    wait_n(9); chk();
    push("up_wrap", 8'h00, 1'b1, 1'b0);
    wait_n(1); chk();
    push("up_wrap_end", 8'h00, 1'b0, 1'b0);
    wait_n(1); chk();
    bus.UP = 1'b0;
    push("dn_hold", 8'h00, 1'b0, 1'b0);
    wait_n(8); chk();
    push("dn_wrap", 8'h99, 1'b1, 1'b0);
    wait_n(1); chk();
    push("dn_wrap_end", 8'h99, 1'b0, 1'b0);
    wait_n(1); chk();
    push("dn_98", 8'h98, 1'b0, 1'b0);
    wait_n(9); chk();

    // Load validity while paused
    bus.EN = 1'b0;
    push("pause2", 8'h98, 1'b0, 1'b0);
    wait_n(3); chk();
    do_load("load47", 8'h47, 8'h98, 1'b0, 8'h47, 1'b0);
    do_load("load4A", 8'h4A, 8'h47, 1'b0, 8'h47, 1'b1);
    do_load("load12", 8'h12, 8'h47, 1'b1, 8'h12, 1'b0);
    do_load("load99", 8'h99, 8'h12, 1'b0, 8'h99, 1'b0);
    do_load("load05", 8'h05, 8'h99, 1'b0, 8'h05, 1'b0);

    // Step mode (count up)
    bus.UP   = 1'b1;
    bus.STEP = 1'b0;
    push("step_before", 8'h05, 1'b0, 1'b0);
    wait_n(2); chk();
    push("step_one", 8'h06, 1'b0, 1'b0);
    wait_n(1); chk();
    wait_n(2);
    bus.STEP = 1'b1;
    push("step_release", 8'h06, 1'b0, 1'b0);
    wait_n(3); chk();
    bus.STEP = 1'b0;
    push("step_hold100", 8'h07, 1'b0, 1'b0);
    wait_n(100); chk();
    bus.STEP = 1'b1;
    push("step_hold_rel", 8'h07, 1'b0, 1'b0);
    wait_n(3); chk();

    // STEP ignored while running
    bus.EN = 1'b1;
    wait_n(2);
    bus.STEP = 1'b0;
    wait_n(5);
    bus.STEP = 1'b1;
    push("run_step_ignored", 8'h07, 1'b0, 1'b0);
    wait_n(4); chk();
    push("run_tick", 8'h08, 1'b0, 1'b0);
    wait_n(1); chk();

    // Load lands on the tick cycle: load wins, count dropped
    wait_n(7);
    bus.LOAD_VAL = 8'h30;
    bus.LOAD     = 1'b1;
    push("coinc_before", 8'h08, 1'b0, 1'b0);
    wait_n(2); chk();
    push("coinc_load", 8'h30, 1'b0, 1'b0);
    wait_n(1); chk();
    bus.LOAD = 1'b0;
    push("coinc_hold", 8'h30, 1'b0, 1'b0);
    wait_n(9); chk();
    push("coinc_next", 8'h31, 1'b0, 1'b0);
    wait_n(1); chk();

    // Load mid-prescale restarts the prescaler
    bus.LOAD_VAL = 8'h56;
    bus.LOAD     = 1'b1;
    push("mid_load", 8'h56, 1'b0, 1'b0);
    wait_n(3); chk();
    bus.LOAD = 1'b0;
    push("mid_no_early", 8'h56, 1'b0, 1'b0);
    wait_n(7); chk();
    push("mid_hold", 8'h56, 1'b0, 1'b0);
    wait_n(2); chk();
    push("mid_count", 8'h57, 1'b0, 1'b0);
    wait_n(1); chk();

    // Invalid load sets the sticky error, then async reset mid-cycle at 57
    bus.LOAD_VAL = 8'hA0;
    bus.LOAD     = 1'b1;
    push("bad_load", 8'h57, 1'b0, 1'b1);
    wait_n(3); chk();
    bus.LOAD = 1'b0;
    bus.UP   = 1'b1;
    #4;
    RST_N = 1'b0;
    #2;
    push("async_reset", 8'h00, 1'b0, 1'b0);
    chk();
    wait_n(2);
    RST_N = 1'b1;
    push("resume_pre", 8'h00, 1'b0, 1'b0);
    wait_n(11); chk();
    push("resume_first", 8'h01, 1'b0, 1'b0);
    wait_n(1); chk();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_counter_2digit.md
Name: bcd_counter_2digit

Overview:
- Two-digit BCD up/down counter producing the tens and units nibbles that feed the two-digit 7-segment decoder stage (DIGIT1 → HEX1 decoder, DIGIT0 → HEX0 decoder).
- Counts at a prescaled rate from the 50 MHz board clock.
- Supports pause, single-step from a pushbutton, direction select, and parallel load of a BCD value from the DIP switches.
- All board inputs are synchronized internally.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- TICK_HZ, 1, count rate while running. PRESCALE = CLK_HZ/TICK_HZ; must be ≥ 2.
- SYNC_STAGES, 2, flip-flop depth of each input synchronizer; must be ≥ 2.

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- EN  in  1  run enable (level): 1 = count on prescaler ticks, 0 = paused.
- UP  in  1  direction (level): 1 = increment, 0 = decrement.
- LOAD  in  1  load request; the rising edge is the event.
- STEP  in  1  active-low pushbutton; the falling edge is the event. Honoured only while paused.
- LOAD_VAL  in  8  BCD load value: [7:4] = tens, [3:0] = units.
- DIGIT1  out  4  tens digit, BCD 0–9, registered.
- DIGIT0  out  4  units digit, BCD 0–9, registered.
- WRAP  out  1  one-cycle pulse on a 99→00 or 00→99 transition.
- LOAD_ERR  out  1  sticky flag: last load was rejected because of non-BCD data.

Behaviour:
- Reset is asynchronous and active-low on RST_N.
- While RST_N = 0:
  - DIGIT1 = 0, DIGIT0 = 0, WRAP = 0, LOAD_ERR = 0.
  - Prescaler = 0.
  - EN, UP and LOAD synchronizer/edge registers = 0; STEP synchronizer/edge registers = 1 (button released).
- After RST_N deasserts, operation starts at the next clock edge. The prescaler restarts from 0.
- Synchronization:
  - EN, UP, LOAD and STEP each pass through a SYNC_STAGES flop chain; the _s suffix denotes the synchronized output.
  - The edge detector compares _s with its own registered copy.
- Latency (default SYNC_STAGES = 2): an input change sampled at edge k produces its event at edge k+2. The digits change at that edge and are visible from then on.
- Prescaler:
  - While EN_s = 1, it counts 0..PRESCALE-1 and wraps to 0.
  - tick = 1 on the cycle the prescaler equals PRESCALE-1 with EN_s = 1.
  - While EN_s = 0, the prescaler is held at 0. A load event also clears it.
- Events, in priority order, at most one applied per cycle:
  1. Load: rising edge of LOAD_s.
     - If both LOAD_VAL nibbles are ≤ 9: DIGIT1/DIGIT0 ← LOAD_VAL and LOAD_ERR ← 0.
     - Otherwise the digits are unchanged and LOAD_ERR ← 1.
     - LOAD_VAL is sampled directly (quasi-static DIP switches) in the event cycle.
  2. Count: tick, OR (falling edge of STEP_s AND EN_s = 0). A STEP edge while EN_s = 1 is ignored.
- A count event coinciding with a load is dropped; it is not deferred.
- Count arithmetic when UP_s = 1:
  - DIGIT0 = 9 → 0 and DIGIT1 increments; otherwise DIGIT0 + 1.
  - DIGIT1 = 9 with a carry → 0 and WRAP = 1.
- Count arithmetic when UP_s = 0:
  - DIGIT0 = 0 → 9 and DIGIT1 decrements; otherwise DIGIT0 − 1.
  - DIGIT1 = 0 with a borrow → 9 and WRAP = 1.
- WRAP:
  - Registered, high for exactly the one cycle after the wrapping edge.
  - Never asserted by a load, even a load of 00 or 99.
- Direction changes take effect on the next count event. There is no extra latency beyond synchronization.
- Defensive rule: any digit register > 9 at a count event is forced to 0 (up) or 9 (down) for that digit. This state is unreachable in normal operation.
- Reset mid-count: the digits clear immediately (asynchronously), any in-flight edge is discarded, and no WRAP is generated.

Test Plan:
- Reset and run: RST_N low for 3 cycles, then high; EN = 1, UP = 1, CLK_HZ = 10, TICK_HZ = 1.
  → Digits 00 during reset. Count reaches 01 exactly 10 cycles after the first tick-eligible cycle. Then 02, 03, … every 10 cycles; 09 → 10 carries correctly.
- Wrap up/down: load 0x98, then run up. → 99, then 00 with WRAP high exactly 1 cycle. Set UP = 0 at 00. → 99 with one WRAP pulse, then 98.
- Load validity: LOAD_VAL = 0x47, pulse LOAD. → 47 two cycles after the LOAD edge, LOAD_ERR = 0. LOAD_VAL = 0x4A, pulse LOAD. → digits stay 47, LOAD_ERR = 1. LOAD_VAL = 0x12, pulse LOAD. → 12, LOAD_ERR = 0.
- Step mode: EN = 0, digits 05; press STEP (low 5 cycles, release). → exactly one increment to 06. Hold STEP low 100 cycles. → still one step. STEP presses with EN = 1 → no extra counts.
- Simultaneous events: align the LOAD rising edge so the load event lands on the tick cycle, with LOAD_VAL = 0x30. → digits = 30 (no count), and the prescaler restarts so the next increment to 31 comes PRESCALE cycles later.
- Async reset mid-run: assert RST_N between clock edges at count 57. → DIGIT1/DIGIT0 = 0 before the next edge, WRAP = 0, LOAD_ERR = 0. After release, counting resumes from 00.
